// File: rtl/yl3_scroller.sv
// yl3_scroller: text-marquee engine that renders DIGITS-wide windows of a
// writable message buffer and hands each frame to the YL-3 driver.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en/addr/char     message buffer write port (any state)
//   len, mode           message length and scroll mode, latched on start
//   run                 level-sensitive scroll enable
//   ready               driver accepts a frame
//   data, load          frame (digit 0 in the top byte) and its strobe
//   busy, pos           engine active, signed window start
module yl3_scroller #(
    parameter int DIGITS      = 8,
    parameter int MSG_DEPTH   = 32,
    parameter int STEP_CYCLES = 6250000,
    localparam int AW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1,
    localparam int LW = $clog2(MSG_DEPTH + 1),
    localparam int PW = $clog2(MSG_DEPTH + DIGITS) + 1,
    localparam int FW = 8 * DIGITS
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_char,
    input  logic [LW-1:0] len,
    input  logic          mode,
    input  logic          run,
    input  logic          ready,
    output logic [FW-1:0] data,
    output logic          load,
    output logic          busy,
    output logic [PW-1:0] pos
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam int HW = $clog2(STEP_CYCLES + 1);
    localparam logic [FW-1:0] BLANK = {DIGITS{8'h20}};

    typedef enum logic [1:0] {
        IDLE,
        BUILD,
        PRESENT,
        HOLD
    } state_t;

    state_t state, state_nx;

    logic [7:0]           mem [MSG_DEPTH];
    logic [7:0]           rd_q;
    logic                 vld_q;
    logic [FW-1:0]        shadow;
    logic [CW-1:0]        bcnt;
    logic [HW-1:0]        hcnt;
    logic signed [PW-1:0] w;
    logic signed [PW-1:0] lim;
    logic                 up;
    logic                 mode_q;
    logic                 stop_q;

    logic signed [PW-1:0] neg_d;
    logic signed [PW-1:0] idx;
    logic                 in_rng;
    logic [AW-1:0]        rd_addr;
    logic [7:0]           byte_in;
    logic [FW-1:0]        frame_nx;
    logic                 last_build;
    logic                 hold_done;
    logic [LW-1:0]        len_c;
    logic signed [PW-1:0] lim_start;
    logic signed [PW-1:0] lo;
    logic signed [PW-1:0] hi;
    logic signed [PW-1:0] w_adv;
    logic                 up_adv;

    // Bounce limits: min/max of 0 and L-DIGITS.
    function automatic logic signed [PW-1:0] lo_of(
        input logic signed [PW-1:0] l
    );
        logic signed [PW-1:0] d;
        d = l - $signed(PW'(DIGITS));
        return d[PW-1] ? d : '0;
    endfunction

    function automatic logic signed [PW-1:0] hi_of(
        input logic signed [PW-1:0] l
    );
        logic signed [PW-1:0] d;
        d = l - $signed(PW'(DIGITS));
        return d[PW-1] ? '0 : d;
    endfunction

    assign neg_d      = -$signed(PW'(DIGITS));
    assign idx        = w + $signed(PW'(bcnt));
    assign in_rng     = !idx[PW-1] && (idx < lim);
    assign rd_addr    = idx[AW-1:0];
    assign byte_in    = vld_q ? rd_q : 8'h20;
    // Truncation keeps the low FW bits: shift left one byte, append new.
    assign frame_nx   = FW'({shadow, byte_in});
    assign last_build = (bcnt == CW'(DIGITS));
    assign hold_done  = (hcnt == HW'(STEP_CYCLES - 1));
    assign len_c      = (len > LW'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : len;
    assign lim_start  = $signed(PW'(len_c));
    assign lo         = lo_of(lim);
    assign hi         = hi_of(lim);
    assign busy       = (state != IDLE);
    assign pos        = w;

    always_comb begin
        w_adv  = w;
        up_adv = up;
        if (!mode_q) begin
            w_adv = (w == lim - PW'(1)) ? neg_d : w + PW'(1);
        end else if (lo != hi) begin
            if (up) begin
                if (w >= hi) begin
                    w_adv  = w - PW'(1);
                    up_adv = 1'b0;
                end else begin
                    w_adv = w + PW'(1);
                end
            end else begin
                if (w <= lo) begin
                    w_adv  = w + PW'(1);
                    up_adv = 1'b1;
                end else begin
                    w_adv = w - PW'(1);
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (run) state_nx = BUILD;
            BUILD:   if (last_build) state_nx = PRESENT;
            PRESENT: begin
                if (ready) state_nx = (stop_q || !run) ? IDLE : HOLD;
            end
            HOLD: begin
                if (!run)          state_nx = IDLE;
                else if (hold_done) state_nx = BUILD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Buffer: one write port, one registered read port, no reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_char;
        rd_q <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data   <= BLANK;
            shadow <= BLANK;
            load   <= 1'b0;
            vld_q  <= 1'b0;
            bcnt   <= '0;
            hcnt   <= '0;
            w      <= '0;
            lim    <= '0;
            up     <= 1'b1;
            mode_q <= 1'b0;
            stop_q <= 1'b0;
        end else begin
            load <= (state == PRESENT) && ready;
            unique case (state)
                IDLE: begin
                    bcnt   <= '0;
                    hcnt   <= '0;
                    stop_q <= 1'b0;
                    if (run) begin
                        lim    <= lim_start;
                        mode_q <= mode;
                        up     <= 1'b1;
                        w      <= mode ? lo_of(lim_start) : neg_d;
                    end
                end
                BUILD: begin
                    // Read for digit bcnt issued now; byte for digit
                    // bcnt-1 arrives from the previous read.
                    vld_q <= in_rng;
                    if (!run) stop_q <= 1'b1;
                    if (bcnt != '0) shadow <= frame_nx;
                    if (last_build) begin
                        data <= frame_nx;
                        bcnt <= '0;
                    end else begin
                        bcnt <= bcnt + CW'(1);
                    end
                end
                PRESENT: begin
                    if (!run) stop_q <= 1'b1;
                    hcnt <= '0;
                end
                HOLD: begin
                    if (run) begin
                        if (hold_done) begin
                            hcnt <= '0;
                            w    <= w_adv;
                            up   <= up_adv;
                        end else begin
                            hcnt <= hcnt + HW'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_yl3_scroller.sv
// tb_yl3_scroller: directed and randomized bench for yl3_scroller with a
// window-rule reference model and precomputed scroll position lists.
module tb_yl3_scroller;

    localparam int D   = 8;
    localparam int M   = 16;
    localparam int S   = 10;
    localparam int PER = D + 2 + S;
    localparam logic [63:0] BLANK = {8{8'h20}};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [7:0]  wr_char = '0;
    logic [4:0]  len = '0;
    logic        mode = 1'b0;
    logic        run = 1'b0;
    logic        ready = 1'b1;
    logic [63:0] data;
    logic        load;
    logic        busy;
    logic [5:0]  pos;

    int          cmp_cnt = 0;
    int          err_cnt = 0;
    logic [7:0]  msg [M];
    bit          last_ready = 1'b1;
    int          n, lw, nl;
    longint      p;
    logic [63:0] d0;
    string       s;

    yl3_scroller #(
        .DIGITS(D),
        .MSG_DEPTH(M),
        .STEP_CYCLES(S)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_char(wr_char),
        .len(len),
        .mode(mode),
        .run(run),
        .ready(ready),
        .data(data),
        .load(load),
        .busy(busy),
        .pos(pos)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mframe(input int w, input int l);
        logic [63:0] f;
        f = BLANK;
        for (int i = 0; i < D; i++) begin
            if (w + i >= 0 && w + i < l) f[63-8*i -: 8] = msg[w+i];
        end
        return f;
    endfunction

    task automatic wr(input int a, input logic [7:0] c);
        wr_en   = 1'b1;
        wr_addr = a[3:0];
        wr_char = c;
        msg[a]  = c;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < M; i++) wr(i, 8'($urandom_range(33, 126)));
    endtask

    task automatic wait_load(input int budget, input bit jit,
                             output int cnt);
        cnt = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            cnt++;
            if (load) begin
                chk("load_with_ready", last_ready, 1'b1);
                ready = 1'b1;
                last_ready = 1'b1;
                return;
            end
            ready = jit ? ($urandom_range(0, 2) != 0) : 1'b1;
            last_ready = ready;
        end
        chk("load_timeout", load, 1'b1);
        cnt = -1;
    endtask

    task automatic play(input int ln, input bit md, input int nfr,
                        input bit jit, input bit per, output int last_w);
        int l;
        int q[$];
        int c;
        int w;
        l = (ln > M) ? M : ln;
        if (!md) begin
            for (int v = -D; v < l; v++) q.push_back(v);
        end else begin
            int lo, hi;
            lo = (l - D < 0) ? l - D : 0;
            hi = (l - D < 0) ? 0 : l - D;
            for (int v = lo; v <= hi; v++) q.push_back(v);
            for (int v = hi - 1; v > lo; v--) q.push_back(v);
        end
        len  = 5'(ln);
        mode = md;
        run  = 1'b1;
        last_w = 0;
        for (int k = 0; k < nfr; k++) begin
            w = q[k % q.size()];
            wait_load(400, jit, c);
            if (per) chk($sformatf("period_%0d", k), c,
                         (k == 0) ? D + 3 : PER);
            chk($sformatf("frame_L%0d_m%0d_k%0d", ln, md, k),
                data, mframe(w, l));
            p = longint'($signed(pos));
            chk($sformatf("pos_k%0d", k), p, w);
            last_w = w;
        end
    endtask

    task automatic stop_idle();
        run = 1'b0;
        ready = 1'b1;
        last_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("busy_after_stop", busy, 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_data", data, BLANK);
        chk("rst_load", load, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pos", pos, 6'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rel_data", data, BLANK);
        chk("rel_busy", busy, 1'b0);

        fill_rand();
        s = "HELLO";
        for (int i = 0; i < s.len(); i++) wr(i, s[i]);

        play(5, 1'b0, 15, 1'b0, 1'b1, lw);
        @(negedge clk);
        chk("load_one_cycle", load, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_load", load, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_data", data, BLANK);
        chk("midrst_pos", pos, 6'd0);
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("postrst_busy", busy, 1'b0);
        chk("postrst_data", data, BLANK);
        chk("postrst_load", load, 1'b0);

        play(5, 1'b1, 14, 1'b0, 1'b1, lw);
        stop_idle();

        s = "HELLO WORLD!";
        for (int i = 0; i < s.len(); i++) wr(i, s[i]);
        play(12, 1'b1, 10, 1'b0, 1'b1, lw);
        stop_idle();

        play(12, 1'b0, 2, 1'b0, 1'b1, lw);
        ready = 1'b0;
        last_ready = 1'b0;
        repeat (20) @(negedge clk);
        d0 = data;
        chk("bp_frame", d0, mframe(-6, 12));
        nl = 0;
        repeat (50) begin
            @(negedge clk);
            nl += int'(load);
        end
        chk("bp_noload", nl, 0);
        chk("bp_stable", data, d0);
        ready = 1'b1;
        last_ready = 1'b1;
        @(negedge clk);
        chk("bp_resume", load, 1'b1);
        wait_load(100, 1'b0, n);
        chk("bp_next_period", n, PER);
        chk("bp_next_frame", data, mframe(-5, 12));
        stop_idle();

        s = "HELLO";
        for (int i = 0; i < s.len(); i++) wr(i, s[i]);
        play(5, 1'b0, 3, 1'b0, 1'b1, lw);
        repeat (12) @(negedge clk);
        run = 1'b0;
        wait_load(40, 1'b0, n);
        chk("stop_last_frame", data, mframe(-5, 5));
        nl = 0;
        repeat (25) begin
            @(negedge clk);
            nl += int'(load);
        end
        chk("stop_noload", nl, 0);
        chk("stop_busy", busy, 1'b0);
        p = longint'($signed(pos));
        chk("stop_pos_hold", p, -5);

        play(0, 1'b0, 10, 1'b0, 1'b1, lw);
        stop_idle();
        play(0, 1'b1, 3, 1'b0, 1'b1, lw);
        stop_idle();

        fill_rand();
        play(20, 1'b0, 26, 1'b0, 1'b1, lw);
        stop_idle();

        for (int t = 0; t < 4; t++) begin
            int rl;
            bit rm;
            fill_rand();
            rl = $urandom_range(0, 20);
            rm = 1'($urandom_range(0, 1));
            play(rl, rm, 12, 1'b1, 1'b0, lw);
            stop_idle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 cmp_cnt, err_cnt);
        $finish;
    end

endmodule
